seq_divider_64by32: RTL

- Iterative radix-2 restoring divider: 2*W-bit dividend / W-bit divisor -> W-bit quotient + W-bit remainder.
- Inverse operation of the 32x32->64 Wallace multiplier; recovers an operand from a product in the matrix datapath.
- Valid/ready handshake on input and output; one operation in flight.

---
 rtl/seq_divider_64by32_pkg.sv | 5 +
 rtl/seq_divider_64by32_if.sv | 27 ++
 rtl/seq_divider_64by32_step.sv | 24 ++
 rtl/seq_divider_64by32.sv | 120 ++++++++++++
 4 files changed

// File: rtl/seq_divider_64by32_pkg.sv
// Shared types and defaults for the sequential 2W/W restoring divider.
package div_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
    localparam int DIV_W_DEFAULT = 32;
endpackage

// File: rtl/seq_divider_64by32_if.sv
// Operand/result handshake bundle for the divider; master drives operands, slave is the divider.
interface seq_divider_64by32_if
    import div_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
);
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider_64by32_step.sv
// One combinational restoring-division iteration: shift in the next quotient bit, trial-subtract D.
module div_step
    import div_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic [W-1:0] i_r,
    input  logic [W-1:0] i_q,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_r_next,
    output logic [W-1:0] o_q_next
);
    logic [W:0]   w_s;
    logic [W+1:0] w_t;
    logic         w_borrow;

    assign w_s = {i_r, i_q[W-1]};
    assign w_t = {1'b0, w_s} - {2'b00, i_d};
    // A successful subtract leaves T < D < 2^W, so any set bit in the top two means borrow.
    assign w_borrow = |w_t[W+1:W];

    assign o_r_next = w_borrow ? w_s[W-1:0] : w_t[W-1:0];
    assign o_q_next = {i_q[W-2:0], ~w_borrow};
endmodule

// File: rtl/seq_divider_64by32.sv
// Iterative radix-2 restoring divider, 2W-bit dividend by W-bit divisor, one operation in flight.
module seq_divider_64by32
    import div_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_divider_64by32_if.slave    bus
);
    localparam int             CW   = $clog2(W);
    localparam logic [CW-1:0]  LAST = CW'(W - 1);

    div_state_t    r_state, w_state;
    // Partial remainder is conceptually W+1 bits, but its top bit is always zero since R < D.
    logic [W-1:0]  r_rem,  w_rem;
    logic [W-1:0]  r_q,    w_q;
    logic [W-1:0]  r_d,    w_d;
    logic [CW-1:0] r_cnt,  w_cnt;
    logic [W-1:0]  r_quot, w_quot;
    logic [W-1:0]  r_remo, w_remo;
    logic          r_dbz,  w_dbz;
    logic          r_ovf,  w_ovf;

    logic [W-1:0]  w_step_r;
    logic [W-1:0]  w_step_q;

    div_step #(.W(W)) u_step (
        .i_r      (r_rem),
        .i_q      (r_q),
        .i_d      (r_d),
        .o_r_next (w_step_r),
        .o_q_next (w_step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_remo  <= '0;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_rem   <= w_rem;
            r_q     <= w_q;
            r_d     <= w_d;
            r_cnt   <= w_cnt;
            r_quot  <= w_quot;
            r_remo  <= w_remo;
            r_dbz   <= w_dbz;
            r_ovf   <= w_ovf;
        end
    end

    always_comb begin
        w_state = r_state;
        w_rem   = r_rem;
        w_q     = r_q;
        w_d     = r_d;
        w_cnt   = r_cnt;
        w_quot  = r_quot;
        w_remo  = r_remo;
        w_dbz   = r_dbz;
        w_ovf   = r_ovf;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.divisor == '0) begin
                        w_dbz   = 1'b1;
                        w_ovf   = 1'b0;
                        w_quot  = '1;
                        w_remo  = bus.dividend[W-1:0];
                        w_state = DONE;
                    end else if (bus.dividend[2*W-1:W] >= bus.divisor) begin
                        // Quotient would need more than W bits.
                        w_dbz   = 1'b0;
                        w_ovf   = 1'b1;
                        w_quot  = '1;
                        w_remo  = '0;
                        w_state = DONE;
                    end else begin
                        w_rem   = bus.dividend[2*W-1:W];
                        w_q     = bus.dividend[W-1:0];
                        w_d     = bus.divisor;
                        w_cnt   = '0;
                        w_state = CALC;
                    end
                end
            end
            CALC: begin
                w_rem = w_step_r;
                w_q   = w_step_q;
                w_cnt = r_cnt + CW'(1);
                if (r_cnt == LAST) begin
                    w_quot  = w_step_q;
                    w_remo  = w_step_r;
                    w_dbz   = 1'b0;
                    w_ovf   = 1'b0;
                    w_state = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    assign bus.in_ready    = (r_state == IDLE);
    assign bus.out_valid   = (r_state == DONE);
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_remo;
    assign bus.div_by_zero = r_dbz;
    assign bus.overflow    = r_ovf;
endmodule
